grf_dump_reader: RTL and testbench

- Debug readout engine for the general register file (GRF).
- On a Start pulse it walks GRF read addresses FIRST_IDX..LAST_IDX through one spare combinational read port. Each register is streamed out as {index, data} beats on a valid/ready interface.
- Sits beside the GRF on the CPU debug path. It is the reading end of the register-write trace: it lets a bench or host compare final architectural state against the write log.
- Also produces a running XOR checksum of all dumped words.

---
 rtl/grf_dump_reader.sv | 83 ++++++++
 tb/tb_grf_dump_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/grf_dump_reader.sv
// rtl/grf_dump_reader.sv - GRF debug dump engine: streams {index, data} beats and keeps an XOR checksum
module grf_dump_reader #(
    parameter int FIRST_IDX = 0,
    parameter int LAST_IDX  = 31,
    parameter int DATA_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Abort,
    output logic [4:0]        Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic              Dump_Valid,
    input  logic              Dump_Ready,
    output logic [4:0]        Dump_Idx,
    output logic [DATA_W-1:0] Dump_Data,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Checksum
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [4:0] FIRST = 5'(FIRST_IDX);
    localparam logic [4:0] LAST  = 5'(LAST_IDX);

    logic [0:0] state;
    logic       handshake;
    logic       at_last;

    assign handshake = Dump_Valid & Dump_Ready;
    assign at_last   = (Dump_Idx == LAST);
    assign Busy      = (state == S_SEND);

    // Read port always points at the next register to capture, so each
    // accepted beat can be replaced by the following one in the same cycle.
    always_comb begin
        Rd_Addr = FIRST;
        if (state == S_SEND) begin
            Rd_Addr = at_last ? LAST : Dump_Idx + 5'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= S_IDLE;
            Dump_Valid <= 1'b0;
            Dump_Idx   <= 5'd0;
            Dump_Data  <= '0;
            Done       <= 1'b0;
            Checksum   <= '0;
        end else begin
            Done <= 1'b0;
            if (state == S_IDLE) begin
                if (Start && !Abort) begin
                    Dump_Data  <= Rd_Data;
                    Dump_Idx   <= FIRST;
                    Dump_Valid <= 1'b1;
                    Checksum   <= '0;
                    state      <= S_SEND;
                end
            end else begin
                // Abort beats a same-cycle handshake; the partial checksum is kept.
                if (Abort) begin
                    Dump_Valid <= 1'b0;
                    state      <= S_IDLE;
                end else if (handshake) begin
                    Checksum <= Checksum ^ Dump_Data;
                    if (at_last) begin
                        Dump_Valid <= 1'b0;
                        Done       <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        Dump_Data <= Rd_Data;
                        Dump_Idx  <= Dump_Idx + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_grf_dump_reader.sv
// tb/tb_grf_dump_reader.sv - scoreboard bench for grf_dump_reader
module tb_grf_dump_reader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start0, start1, abort, ready;
    logic [4:0]  rd_addr0, rd_addr1, idx0, idx1;
    logic [31:0] rd_data0, rd_data1, data0, data1, cks0, cks1;
    logic        valid0, valid1, busy0, busy1, done0, done1;
    logic [31:0] grf [32];

    always #5 Clk = ~Clk;

    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'd0 : grf[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : grf[rd_addr1];

    grf_dump_reader #(.FIRST_IDX(0), .LAST_IDX(31), .DATA_W(32)) dut0 (
        .Clk(Clk), .Rst(Rst), .Start(start0), .Abort(abort),
        .Rd_Addr(rd_addr0), .Rd_Data(rd_data0),
        .Dump_Valid(valid0), .Dump_Ready(ready), .Dump_Idx(idx0), .Dump_Data(data0),
        .Busy(busy0), .Done(done0), .Checksum(cks0)
    );

    grf_dump_reader #(.FIRST_IDX(31), .LAST_IDX(31), .DATA_W(32)) dut1 (
        .Clk(Clk), .Rst(Rst), .Start(start1), .Abort(1'b0),
        .Rd_Addr(rd_addr1), .Rd_Data(rd_data1),
        .Dump_Valid(valid1), .Dump_Ready(ready), .Dump_Idx(idx1), .Dump_Data(data1),
        .Busy(busy1), .Done(done1), .Checksum(cks1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [36:0] exp_q [$];
    logic [31:0] run_cks;
    int          beat_cnt, done_cnt, cyc, last_cyc;
    logic        prev_stall;
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;

    initial begin
        run_cks = '0; beat_cnt = 0; done_cnt = 0; cyc = 0; last_cyc = -10;
        prev_stall = 1'b0; prev_idx = '0; prev_data = '0;
    end

    // Scoreboard side: every accepted beat of dut0 must match the queue head.
    always @(negedge Clk) begin
        logic [36:0] e;
        cyc++;
        if (!Rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", valid0, 1);
                chk("hold_idx", idx0, prev_idx);
                chk("hold_data", data0, prev_data);
            end
            if (done0) begin
                done_cnt++;
                chk("done_after_last", cyc, last_cyc + 1);
                chk("done_q_empty", exp_q.size(), 0);
            end
            if (valid0 && ready && !abort) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", idx0, e[36:32]);
                    chk("beat_data", data0, e[31:0]);
                    run_cks  = run_cks ^ data0;
                    beat_cnt++;
                    last_cyc = cyc;
                end
            end
            prev_stall = valid0 && !ready && !abort;
            prev_idx   = idx0;
            prev_data  = data0;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] model_cks(input int lo, input int hi);
        logic [31:0] x = '0;
        for (int i = lo; i <= hi; i++) x = x ^ ((i == 0) ? 32'd0 : grf[i]);
        return x;
    endfunction

    task automatic pulse_start();
        for (int i = 0; i <= 31; i++) exp_q.push_back({5'(i), (i == 0) ? 32'd0 : grf[i]});
        run_cks  = '0;
        beat_cnt = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("first_beat_latency", {valid0, busy0, idx0}, {1'b1, 1'b1, 5'd0});
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic wait_idx(input logic [4:0] target, input int budget);
        int n = 0;
        while (!(valid0 && idx0 == target) && n < budget) begin
            tick();
            n++;
        end
        chk("reach_idx", idx0, target);
    endtask

    int pat [4] = '{1, 0, 0, 1};

    initial begin
        int d0, n;
        Rst = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; ready = 1'b1;
        for (int i = 0; i < 32; i++) grf[i] = (i == 0) ? 32'd0 : 32'h1000 + i;
        #23;
        chk("reset_outputs", {valid0, idx0, data0, busy0, done0, cks0},
            {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        tick();
        Rst = 1'b1;
        tick();

        // Abort beats Start while idle
        abort = 1'b1; start0 = 1'b1;
        tick();
        abort = 1'b0; start0 = 1'b0;
        tick();
        chk("idle_abort_wins", {valid0, busy0}, 2'b00);

        // Full dump, ready always high
        pulse_start();
        wait_done(100);
        chk("t1_beats", beat_cnt, 32);
        chk("t1_cks", cks0, model_cks(0, 31));
        chk("t1_run_cks", run_cks, model_cks(0, 31));
        chk("t1_busy_after", busy0, 0);

        // Backpressure 1,0,0,1
        d0 = done_cnt; n = 0;
        pulse_start();
        while (done_cnt == d0 && n < 400) begin
            ready = pat[n % 4][0];
            tick();
            n++;
        end
        ready = 1'b1;
        chk("t2_done_seen", done_cnt, d0 + 1);
        chk("t2_beats", beat_cnt, 32);
        chk("t2_cks", cks0, model_cks(0, 31));

        // Abort while beat 10 is valid and ready
        d0 = done_cnt;
        pulse_start();
        wait_idx(5'd10, 50);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid_busy", {valid0, busy0}, 2'b00);
        chk("abort_cks", cks0, model_cks(0, 9));
        chk("abort_run_cks", run_cks, model_cks(0, 9));
        exp_q.delete();
        repeat (40) tick();
        chk("abort_no_done", done_cnt, d0);
        chk("abort_cks_hold", cks0, model_cks(0, 9));

        // Start mid-dump is ignored
        pulse_start();
        wait_idx(5'd4, 50);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("mid_start_next", idx0, 5'd5);
        wait_done(100);
        chk("mid_start_beats", beat_cnt, 32);

        // Asynchronous reset mid-dump
        d0 = done_cnt;
        pulse_start();
        wait_idx(5'd20, 50);
        #2;
        Rst = 1'b0;
        #1;
        chk("async_reset_outputs", {valid0, idx0, data0, busy0, done0, cks0},
            {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0});
        exp_q.delete();
        tick();
        Rst = 1'b1;
        tick();
        chk("reset_no_done", done_cnt, d0);
        pulse_start();
        wait_done(100);
        chk("post_reset_beats", beat_cnt, 32);

        // Single-register dump on the FIRST==LAST instance
        grf[31] = 32'hDEADBEEF;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("single_beat", {valid1, busy1, idx1, data1}, {1'b1, 1'b1, 5'd31, 32'hDEADBEEF});
        tick();
        chk("single_done", {valid1, busy1, done1}, 3'b001);
        chk("single_cks", cks1, 32'hDEADBEEF);
        tick();
        chk("single_done_pulse", done1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
